// File: rtl/mappy_spr_scan.sv
// mappy_spr_scan: per-line sprite attribute scanner feeding a first-word fall-through draw-job queue.
// state | meaning
// IDLE  | waiting for line_start
// RD0   | even (tile/ypos/attr) address on ab_obj
// RD1   | odd (pal/x/disable) address on ab_obj, even data captured
// EVAL  | odd data live on the RAM bus, vertical hit evaluated, job pushed
// WAIT  | hit found with the queue full, holding the job until a slot frees
module mappy_spr_scan #(
    parameter int          NUM_SPR    = 64,
    parameter logic [10:0] BASE_ADDR  = 11'h780,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk_36864,
    input  logic        n_main_reset,
    input  logic        line_start,
    input  logic [7:0]  vline,
    output logic [10:0] ab_obj,
    input  logic [7:0]  obj1in,
    input  logic [7:0]  obj2in,
    input  logic [7:0]  obj3in,
    output logic        job_valid,
    input  logic        job_ready,
    output logic [7:0]  job_tile,
    output logic [5:0]  job_pal,
    output logic [8:0]  job_xpos,
    output logic [4:0]  job_row,
    output logic [1:0]  job_size,
    output logic        job_flipx,
    output logic        scan_busy,
    output logic        line_done,
    output logic [6:0]  match_count
);

    localparam int KW = $clog2(NUM_SPR);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_RD0, S_RD1, S_EVAL, S_WAIT} state_t;

    typedef struct packed {
        logic [7:0] tile;
        logic [5:0] pal;
        logic [8:0] xpos;
        logic [4:0] row;
        logic [1:0] size;
        logic       flipx;
    } job_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d, k_next;
    logic [7:0]    vline_q, vline_d;
    logic [10:0]   ab_q, ab_d;
    logic [7:0]    tile_q, tile_d;
    logic [7:0]    ypos_q, ypos_d;
    logic [3:0]    attr_q, attr_d;
    job_t          pend_q, pend_d;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic [6:0]    mc_q, mc_d;
    job_t          mem_q [FIFO_DEPTH];

    logic [8:0] y;
    logic       hit, last, full, stall, push, pop, advance;
    job_t       eval_job, push_job, head;
    logic       unused_obj3;

    assign unused_obj3 = ^obj3in[7:4];
    assign last        = (k_q == KW'(NUM_SPR - 1));
    assign k_next      = last ? '0 : k_q + 1'b1;
    assign full        = (cnt_q == (PW + 1)'(FIFO_DEPTH));
    assign pop         = job_valid & job_ready;

    // attr_q = {size[1:0], flipy, flipx} of the even word
    always_comb begin
        y = {1'b0, ypos_q} + {1'b0, vline_q} + (attr_q[3] ? 9'd16 : 9'd0) - 9'd1;
        if (attr_q[3]) begin
            hit          = (y[8:5] == 4'b0111);
            eval_job.row = y[4:0] ^ {5{attr_q[1]}};
        end else begin
            hit          = (y[8:4] == 5'b01110);
            eval_job.row = {1'b0, y[3:0] ^ {4{attr_q[1]}}};
        end
        eval_job.tile  = tile_q;
        eval_job.pal   = obj1in[5:0];
        eval_job.xpos  = {obj3in[0], obj2in};
        eval_job.size  = attr_q[3:2];
        eval_job.flipx = attr_q[0];
        stall          = hit & ~obj3in[1] & full;
    end

    always_ff @(posedge clk_36864 or negedge n_main_reset) begin
        if (!n_main_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_RD0:  state_d = S_RD1;
            S_RD1:  state_d = S_EVAL;
            S_EVAL: begin
                if (stall)     state_d = S_WAIT;
                else if (last) state_d = S_IDLE;
                else           state_d = S_RD0;
            end
            S_WAIT: begin
                if (!full) state_d = last ? S_IDLE : S_RD0;
            end
            default: state_d = S_IDLE;
        endcase
        if (line_start) state_d = S_RD0;
    end

    always_comb begin
        push     = 1'b0;
        advance  = 1'b0;
        push_job = pend_q;
        if (!line_start) begin
            if (state_q == S_EVAL) begin
                push     = hit & ~obj3in[1] & ~full;
                advance  = ~stall;
                push_job = eval_job;
            end else if (state_q == S_WAIT) begin
                push    = ~full;
                advance = ~full;
            end
        end
        line_done = advance & last;
        scan_busy = (state_q != S_IDLE) & ~line_done;
    end

    always_comb begin
        k_d     = k_q;
        vline_d = vline_q;
        ab_d    = ab_q;
        tile_d  = tile_q;
        ypos_d  = ypos_q;
        attr_d  = attr_q;
        pend_d  = pend_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        mc_d    = mc_q;
        if (state_q == S_RD0) ab_d = ab_q + 11'd1;
        if (state_q == S_RD1) begin
            tile_d = obj1in;
            ypos_d = obj2in;
            attr_d = obj3in[3:0];
        end
        if (state_q == S_EVAL) pend_d = eval_job;
        if (advance) begin
            k_d = k_next;
            if (!last) ab_d = BASE_ADDR + 11'({k_next, 1'b0});
        end
        if (push) begin
            wr_d = wr_q + 1'b1;
            if (mc_q != 7'd127) mc_d = mc_q + 7'd1;
        end
        if (pop) rd_d = rd_q + 1'b1;
        cnt_d = cnt_q + (PW + 1)'(push) - (PW + 1)'(pop);
        // a new line start discards everything queued for the old line
        if (line_start) begin
            k_d     = '0;
            vline_d = vline;
            ab_d    = BASE_ADDR;
            wr_d    = '0;
            rd_d    = '0;
            cnt_d   = '0;
            mc_d    = '0;
        end
    end

    always_ff @(posedge clk_36864 or negedge n_main_reset) begin
        if (!n_main_reset) begin
            k_q     <= '0;
            vline_q <= '0;
            ab_q    <= BASE_ADDR;
            tile_q  <= '0;
            ypos_q  <= '0;
            attr_q  <= '0;
            pend_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            mc_q    <= '0;
        end else begin
            k_q     <= k_d;
            vline_q <= vline_d;
            ab_q    <= ab_d;
            tile_q  <= tile_d;
            ypos_q  <= ypos_d;
            attr_q  <= attr_d;
            pend_q  <= pend_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            mc_q    <= mc_d;
        end
    end

    always_ff @(posedge clk_36864) begin
        if (push) mem_q[wr_q] <= push_job;
    end

    assign head        = mem_q[rd_q];
    assign job_valid   = (cnt_q != '0);
    assign ab_obj      = ab_q;
    assign match_count = mc_q;

    always_comb begin
        job_tile  = '0;
        job_pal   = '0;
        job_xpos  = '0;
        job_row   = '0;
        job_size  = '0;
        job_flipx = 1'b0;
        if (job_valid) begin
            job_tile  = head.tile;
            job_pal   = head.pal;
            job_xpos  = head.xpos;
            job_row   = head.row;
            job_size  = head.size;
            job_flipx = head.flipx;
        end
    end

endmodule
